// File: rtl/amba3_axi_wr_slave_pkg.sv
// Shared types for the AXI3 write-path slave: burst encodings, response
// codes, FSM state encoding and a small helper for WRAP length legality.
package amba3_axi_wr_slave_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam int LEN_BITS  = 4;
    localparam int SIZE_BITS = 3;

    // A WRAP burst must be 2, 4, 8 or 16 beats long.
    function automatic logic wrap_len_ok(input logic [LEN_BITS-1:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/amba3_axi_wr_slave_beat_addr.sv
// Per-beat address generator: from the current beat address and the latched
// burst command, computes the address of the following beat and the byte
// lanes the current beat occupies on the data bus. Purely combinational.
module amba3_axi_beat_addr
    import amba3_axi_wr_slave_pkg::*;
#(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 128
) (
    input  logic [ADDR_BITS-1:0]   cur_addr,
    input  logic [ADDR_BITS-1:0]   start_addr,
    input  logic [LEN_BITS-1:0]    len,
    input  logic [SIZE_BITS-1:0]   size,
    input  logic [1:0]             burst,
    output logic [ADDR_BITS-1:0]   next_addr,
    output logic [DATA_BITS/8-1:0] lane_mask
);

    localparam int STRB_BITS = DATA_BITS / 8;
    localparam logic [ADDR_BITS-1:0] ONE     = ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] STRB_M1 = ADDR_BITS'(STRB_BITS - 1);

    logic [ADDR_BITS-1:0] size_bytes;
    logic [ADDR_BITS-1:0] size_m1;
    logic [ADDR_BITS-1:0] wrap_bytes;
    logic [ADDR_BITS-1:0] wrap_low;
    logic [ADDR_BITS-1:0] seq_addr;
    logic [ADDR_BITS-1:0] incr_addr;
    logic [ADDR_BITS-1:0] lane_lo;
    logic [ADDR_BITS-1:0] lane_hi;

    // Next beat address: INCR realigns to the transfer size after beat 0,
    // WRAP folds back to the wrap-window base when it reaches the window end.
    always_comb begin
        size_bytes = ONE << size;
        size_m1    = size_bytes - ONE;
        wrap_bytes = (ADDR_BITS'(len) + ONE) * size_bytes;
        wrap_low   = start_addr & ~(wrap_bytes - ONE);
        seq_addr   = cur_addr + size_bytes;
        incr_addr  = (cur_addr & ~size_m1) + size_bytes;
        next_addr  = cur_addr;
        case (burst)
            FIXED:   next_addr = cur_addr;
            INCR:    next_addr = incr_addr;
            WRAP:    next_addr = (seq_addr == wrap_low + wrap_bytes) ? wrap_low : seq_addr;
            default: next_addr = cur_addr;
        endcase
    end

    // Active lanes run from the beat's own byte offset up to the end of its
    // size-aligned container, both taken modulo the bus width.
    always_comb begin
        lane_lo   = cur_addr & STRB_M1;
        lane_hi   = (cur_addr | size_m1) & STRB_M1;
        lane_mask = '0;
        for (int i = 0; i < STRB_BITS; i++) begin
            lane_mask[i] = (ADDR_BITS'(i) >= lane_lo) && (ADDR_BITS'(i) <= lane_hi);
        end
    end

endmodule

// File: rtl/amba3_axi_wr_slave.sv
// AXI3 write-path slave front end. Accepts one AW burst at a time, walks the
// burst beat by beat onto an SRAM-style write port with lane-masked strobes,
// and returns one B response per burst.
//
// Handshakes: a transfer on any channel (AW, W, B) happens on the rising edge
// where both valid and ready are high. The sender holds valid and payload
// stable until that edge; ready may rise or fall freely. On W, ready is
// simply mem_ready while a burst is in its data phase, so a write beat and a
// memory write happen on the same edge.
module amba3_axi_wr_slave
    import amba3_axi_wr_slave_pkg::*;
#(
    parameter int TXID_BITS = 4,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 128
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [TXID_BITS-1:0]   awid,
    input  logic [ADDR_BITS-1:0]   awaddr,
    input  logic [3:0]             awlen,
    input  logic [2:0]             awsize,
    input  logic [1:0]             awburst,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [TXID_BITS-1:0]   wid,
    input  logic [DATA_BITS-1:0]   wdata,
    input  logic [DATA_BITS/8-1:0] wstrb,
    input  logic                   wlast,
    input  logic                   wvalid,
    output logic                   wready,
    output logic [TXID_BITS-1:0]   bid,
    output logic [1:0]             bresp,
    output logic                   bvalid,
    input  logic                   bready,
    output logic                   mem_we,
    output logic [ADDR_BITS-1:0]   mem_addr,
    output logic [DATA_BITS-1:0]   mem_wdata,
    output logic [DATA_BITS/8-1:0] mem_wstrb,
    input  logic                   mem_ready,
    output logic [1:0]             dbg_state
);

    localparam int STRB_BITS = DATA_BITS / 8;
    localparam int DATA_BASE = $clog2(STRB_BITS);
    localparam logic [2:0] MAX_SIZE = 3'(DATA_BASE);

    state_t                 state;
    logic [TXID_BITS-1:0]   id_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [ADDR_BITS-1:0]   start_q;
    logic [3:0]             len_q;
    logic [2:0]             size_q;
    logic [1:0]             burst_q;
    logic [3:0]             beat_q;
    logic                   cmd_err_q;
    logic                   beat_err_q;

    logic [ADDR_BITS-1:0]   next_addr;
    logic [STRB_BITS-1:0]   lane_mask;
    logic [ADDR_BITS-1:0]   aw_size_bytes;
    logic                   aw_cmd_err;
    logic                   w_acc;
    logic                   last_beat;
    logic                   beat_bad;

    amba3_axi_beat_addr #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_beat_addr (
        .cur_addr   (addr_q),
        .start_addr (start_q),
        .len        (len_q),
        .size       (size_q),
        .burst      (burst_q),
        .next_addr  (next_addr),
        .lane_mask  (lane_mask)
    );

    // Command legality is judged once, on the AW payload, and held for the burst.
    always_comb begin
        aw_size_bytes = ADDR_BITS'(1) << awsize;
        aw_cmd_err    = (awsize > MAX_SIZE)
                      || (awburst == 2'b11)
                      || ((awburst == WRAP)
                          && (!wrap_len_ok(awlen) || (|(awaddr & (aw_size_bytes - ADDR_BITS'(1))))));
    end

    // Data-phase beat acceptance, memory port drive and per-beat protocol checks.
    always_comb begin
        wready    = (state == DATA) && mem_ready;
        w_acc     = wready && wvalid;
        mem_we    = w_acc && !cmd_err_q;
        mem_addr  = addr_q;
        mem_wdata = wdata;
        mem_wstrb = wstrb & lane_mask;
        last_beat = (beat_q == len_q);
        beat_bad  = (wid != id_q) || (wlast != last_beat);
        dbg_state = state;
    end

    // Burst FSM: IDLE takes a command, DATA consumes len+1 beats, RESP holds B.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            awready    <= 1'b0;
            bvalid     <= 1'b0;
            bid        <= '0;
            bresp      <= OKAY;
            id_q       <= '0;
            addr_q     <= '0;
            start_q    <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            beat_q     <= '0;
            cmd_err_q  <= 1'b0;
            beat_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (awvalid && awready) begin
                        id_q       <= awid;
                        addr_q     <= awaddr;
                        start_q    <= awaddr;
                        len_q      <= awlen;
                        size_q     <= awsize;
                        burst_q    <= awburst;
                        beat_q     <= '0;
                        cmd_err_q  <= aw_cmd_err;
                        beat_err_q <= 1'b0;
                        awready    <= 1'b0;
                        state      <= DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                DATA: begin
                    if (w_acc) begin
                        addr_q     <= next_addr;
                        beat_q     <= beat_q + 4'd1;
                        beat_err_q <= beat_err_q || beat_bad;
                        if (last_beat) begin
                            state  <= RESP;
                            bvalid <= 1'b1;
                            bid    <= id_q;
                            bresp  <= (cmd_err_q || beat_err_q || beat_bad) ? SLVERR : OKAY;
                        end
                    end
                end
                RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    awready <= 1'b0;
                    bvalid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_amba3_axi_wr_slave.sv
// Bench for amba3_axi_wr_slave: directed and random bursts, a byte-level
// reference model of beat addresses and lanes, and a monitor that pops the
// expected queues whenever the DUT writes memory or completes a B handshake.
module tb_amba3_axi_wr_slave;
    import amba3_axi_wr_slave_pkg::*;

    localparam int TXID_BITS = 4;
    localparam int ADDR_BITS = 32;
    localparam int DATA_BITS = 128;
    localparam int STRB_BITS = 16;
    localparam int MW        = ADDR_BITS + STRB_BITS + DATA_BITS;
    localparam int BW        = TXID_BITS + 2;
    localparam int MAXWAIT   = 200;

    logic                 aclk;
    logic                 areset;
    logic [TXID_BITS-1:0] awid;
    logic [ADDR_BITS-1:0] awaddr;
    logic [3:0]           awlen;
    logic [2:0]           awsize;
    logic [1:0]           awburst;
    logic                 awvalid;
    logic                 awready;
    logic [TXID_BITS-1:0] wid;
    logic [DATA_BITS-1:0] wdata;
    logic [STRB_BITS-1:0] wstrb;
    logic                 wlast;
    logic                 wvalid;
    logic                 wready;
    logic [TXID_BITS-1:0] bid;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0] mem_wdata;
    logic [STRB_BITS-1:0] mem_wstrb;
    logic                 mem_ready;
    logic [1:0]           dbg_state;

    logic [MW-1:0] exp_q[$];
    logic [BW-1:0] exp_b_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int mr_low_cnt = 0;
    bit mr_rand = 1'b0;

    amba3_axi_wr_slave #(
        .TXID_BITS (TXID_BITS),
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .awid      (awid),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awsize    (awsize),
        .awburst   (awburst),
        .awvalid   (awvalid),
        .awready   (awready),
        .wid       (wid),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bid       (bid),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_addr(input logic [31:0] a, input int n, input int len,
                                               input int size, input logic [1:0] burst);
        longint s, w, low, av;
        s  = longint'(1) << size;
        av = {32'd0, a};
        case (burst)
            2'b01: begin
                if (n == 0) return a;
                return 32'((av / s) * s + longint'(n) * s);
            end
            2'b10: begin
                w   = longint'(len + 1) * s;
                low = (av / w) * w;
                return 32'(low + ((av - low) + longint'(n) * s) % w);
            end
            default: return a;
        endcase
    endfunction

    // Lanes touched by the bytes from the beat address to the end of its size container.
    function automatic logic [STRB_BITS-1:0] model_lanes(input logic [31:0] a, input int size);
        longint s, first, last;
        logic [STRB_BITS-1:0] m;
        s     = longint'(1) << size;
        first = {32'd0, a};
        last  = (first / s) * s + s - 1;
        m     = '0;
        for (longint b = first; b <= last; b++) m[int'(b % STRB_BITS)] = 1'b1;
        return m;
    endfunction

    function automatic bit model_cmd_err(input logic [31:0] a, input int len, input int size,
                                         input logic [1:0] burst);
        longint s;
        s = longint'(1) << size;
        if (size > $clog2(STRB_BITS)) return 1'b1;
        if (burst == 2'b11) return 1'b1;
        if (burst == 2'b10) begin
            if (!(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
            if (({32'd0, a} % s) != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // ---------------- memory-ready driver ----------------
    initial begin
        mem_ready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            if (mr_low_cnt > 0) begin
                mem_ready  = 1'b0;
                mr_low_cnt = mr_low_cnt - 1;
            end else if (mr_rand) begin
                mem_ready = ($urandom_range(0, 3) != 0);
            end else begin
                mem_ready = 1'b1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [MW-1:0] e;
        logic [BW-1:0] eb;
        forever begin
            @(negedge aclk);
            if (!areset) begin
                check("wready_without_mem_ready", 128'(wready && !mem_ready), 128'(0));
                check("mem_we_without_w_handshake", 128'(mem_we && !(wvalid && wready)), 128'(0));
                if (mem_we) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_mem_we", 128'(mem_addr), 128'(0));
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_mem_we: got write at %0h expected none", mem_addr);
                    end else begin
                        e = exp_q.pop_front();
                        check("mem_addr", 128'(mem_addr), 128'(e[MW-1 -: ADDR_BITS]));
                        check("mem_wstrb", 128'(mem_wstrb), 128'(e[DATA_BITS +: STRB_BITS]));
                        check("mem_wdata", mem_wdata, e[DATA_BITS-1:0]);
                    end
                end
                if (bvalid && bready) begin
                    if (exp_b_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_b: got bid %0h bresp %0h expected none", bid, bresp);
                    end else begin
                        eb = exp_b_q.pop_front();
                        check("bid", 128'(bid), 128'(eb[BW-1:2]));
                        check("bresp", 128'(bresp), 128'(eb[1:0]));
                    end
                end
            end
        end
    end

    // ---------------- burst driver ----------------
    // bad_wid / bad_last: beat index to corrupt (-1 none); mr_stall_beat: beat
    // before which mem_ready is forced low 3 cycles; reset_after: beat after
    // which areset is pulsed (-1 none).
    task automatic run_burst(input logic [3:0] id, input logic [31:0] a, input int len,
                             input int size, input logic [1:0] burst,
                             input int bad_wid, input int bad_last, input int bstall,
                             input int mr_stall_beat, input int reset_after);
        logic [DATA_BITS-1:0] wd[16];
        logic [STRB_BITS-1:0] ws[16];
        logic [1:0]           exp_resp;
        bit                   cerr, berr, hs;
        cerr = model_cmd_err(a, len, size, burst);
        berr = (bad_wid >= 0 && bad_wid <= len) || (bad_last >= 0 && bad_last <= len);
        exp_resp = (cerr || berr) ? 2'(SLVERR) : 2'(OKAY);
        for (int n = 0; n <= len; n++) begin
            wd[n] = {$urandom, $urandom, $urandom, $urandom};
            ws[n] = ($urandom_range(0, 1) == 1) ? 16'hffff : 16'($urandom);
            if (!cerr)
                exp_q.push_back({model_addr(a, n, len, size, burst),
                                 ws[n] & model_lanes(model_addr(a, n, len, size, burst), size),
                                 wd[n]});
        end
        // AW
        awid = id; awaddr = a; awlen = 4'(len); awsize = 3'(size); awburst = burst;
        awvalid = 1'b1;
        hs = 1'b0;
        for (int c = 0; c < MAXWAIT && !hs; c++) begin
            @(negedge aclk);
            hs = awready;
            @(posedge aclk);
            #1;
        end
        awvalid = 1'b0;
        if (!hs) begin
            timeout_fail("aw_handshake");
            return;
        end
        // W beats
        for (int n = 0; n <= len; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                @(posedge aclk);
                #1;
            end
            if (n == mr_stall_beat) mr_low_cnt = 3;
            wvalid = 1'b1;
            wid    = (n == bad_wid) ? (id ^ 4'h5) : id;
            wdata  = wd[n];
            wstrb  = ws[n];
            wlast  = (n == len) ^ (n == bad_last);
            hs = 1'b0;
            for (int c = 0; c < MAXWAIT && !hs; c++) begin
                @(negedge aclk);
                hs = wready;
                @(posedge aclk);
                #1;
            end
            if (!hs) begin
                wvalid = 1'b0;
                timeout_fail("w_handshake");
                return;
            end
            if (n == reset_after) begin
                wvalid = 1'b0;
                areset = 1'b1;
                exp_q.delete();
                exp_b_q.delete();
                @(posedge aclk);
                #1;
                areset = 1'b0;
                @(negedge aclk);
                check("abort_state_idle", 128'(dbg_state), 128'(IDLE));
                check("abort_bvalid", 128'(bvalid), 128'(0));
                check("abort_awready_low", 128'(awready), 128'(0));
                check("abort_mem_we", 128'(mem_we), 128'(0));
                @(posedge aclk);
                #1;
                @(negedge aclk);
                check("abort_awready_high", 128'(awready), 128'(1));
                @(posedge aclk);
                #1;
                return;
            end
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        exp_b_q.push_back({id, exp_resp});
        // B
        bready = 1'b0;
        hs = 1'b0;
        for (int c = 0; c < MAXWAIT && !hs; c++) begin
            @(negedge aclk);
            hs = bvalid;
            if (!hs) begin
                @(posedge aclk);
                #1;
            end
        end
        if (!hs) begin
            timeout_fail("bvalid_wait");
            return;
        end
        for (int k = 0; k < bstall; k++) begin
            @(posedge aclk);
            #1;
            @(negedge aclk);
            check("stall_bvalid", 128'(bvalid), 128'(1));
            check("stall_bid", 128'(bid), 128'(id));
            check("stall_bresp", 128'(bresp), 128'(exp_resp));
            check("stall_awready", 128'(awready), 128'(0));
        end
        @(posedge aclk);
        #1;
        bready = 1'b1;
        @(negedge aclk);
        check("b_handshake_bvalid", 128'(bvalid), 128'(1));
        check("b_handshake_awready", 128'(awready), 128'(0));
        @(posedge aclk);
        #1;
        bready = 1'b0;
        @(negedge aclk);
        check("post_b_awready", 128'(awready), 128'(1));
        check("post_b_bvalid", 128'(bvalid), 128'(0));
        @(posedge aclk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] ra;
        int rlen, rsize, rbw, rbl;
        logic [1:0] rburst;
        areset = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_awready", 128'(awready), 128'(0));
        check("rst_wready", 128'(wready), 128'(0));
        check("rst_bvalid", 128'(bvalid), 128'(0));
        check("rst_bid", 128'(bid), 128'(0));
        check("rst_bresp", 128'(bresp), 128'(OKAY));
        check("rst_mem_we", 128'(mem_we), 128'(0));
        check("rst_mem_addr", 128'(mem_addr), 128'(0));
        check("rst_state", 128'(dbg_state), 128'(IDLE));
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        check("awready_still_low", 128'(awready), 128'(0));
        @(posedge aclk);
        #1;
        @(negedge aclk);
        check("awready_after_reset", 128'(awready), 128'(1));
        @(posedge aclk);
        #1;

        // directed bursts
        run_burst(4'h1, 32'h0000_0104, 3, 2, INCR,  -1, -1, 0, -1, -1);
        run_burst(4'h2, 32'h0000_0201, 2, 3, INCR,  -1, -1, 1, -1, -1);
        run_burst(4'h3, 32'h0000_021C, 3, 1, WRAP,  -1, -1, 0, -1, -1);
        run_burst(4'h4, 32'h0000_0106, 4, 0, FIXED, -1, -1, 0, -1, -1);
        run_burst(4'h5, 32'h0000_0300, 7, 4, INCR,  -1, -1, 5,  2, -1);
        run_burst(4'h6, 32'h0000_0400, 3, 2, INCR,   1, -1, 0, -1, -1);
        run_burst(4'h7, 32'h0000_0500, 2, 2, WRAP,  -1, -1, 0, -1, -1);
        run_burst(4'h8, 32'h0000_0600, 3, 2, INCR,  -1,  1, 0, -1, -1);
        run_burst(4'h9, 32'h0000_0640, 3, 2, INCR,  -1,  3, 0, -1, -1);
        run_burst(4'hA, 32'h0000_0702, 3, 2, WRAP,  -1, -1, 0, -1, -1);
        run_burst(4'hB, 32'h0000_0800, 1, 5, INCR,  -1, -1, 0, -1, -1);
        run_burst(4'hC, 32'h0000_0900, 1, 2, 2'b11, -1, -1, 0, -1, -1);
        run_burst(4'hD, 32'hFFFF_FFF8, 3, 3, INCR,  -1, -1, 0, -1, -1);
        run_burst(4'hE, 32'h0000_0A00, 7, 2, INCR,  -1, -1, 0, -1,  2);
        run_burst(4'hF, 32'h0000_0B08, 15, 4, WRAP, -1, -1, 2, -1, -1);
        run_burst(4'h0, 32'h0000_0C00, 0, 4, INCR,  -1, -1, 0, -1, -1);

        // random bursts
        mr_rand = 1'b1;
        for (int t = 0; t < 40; t++) begin
            rburst = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0) rburst = 2'b11;
            rsize = ($urandom_range(0, 15) == 0) ? 5 + $urandom_range(0, 2) : $urandom_range(0, 4);
            rlen  = $urandom_range(0, 15);
            ra    = $urandom;
            if (rburst == 2'b10 && $urandom_range(0, 9) != 0) begin
                case ($urandom_range(0, 3))
                    0: rlen = 1;
                    1: rlen = 3;
                    2: rlen = 7;
                    default: rlen = 15;
                endcase
                ra = ra & ~((32'd1 << rsize) - 32'd1);
            end
            rbw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, rlen) : -1;
            rbl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, rlen) : -1;
            run_burst(4'($urandom), ra, rlen, rsize, rburst, rbw, rbl,
                      $urandom_range(0, 3), -1, -1);
        end
        mr_rand = 1'b0;

        repeat (4) @(posedge aclk);
        #1;
        check("exp_mem_queue_drained", 128'(exp_q.size()), 128'(0));
        check("exp_b_queue_drained", 128'(exp_b_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
